iter_alu: RTL and testbench

Parametrised multi-cycle successor to the CPU's single-cycle main ALU. It keeps the existing 5-bit opcode map for register arithmetic and logic, and adds iterative unsigned multiply, divide and remainder. A valid/ready handshake on input and output lets the control unit stall the pipeline while a long operation runs. It sits between the register-file read ports and the writeback mux.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/iter_muldiv_core.sv | 121 ++++++++++++
 rtl/iter_alu.sv | 127 ++++++++++++
 tb/tb_iter_alu.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_pkg : opcode map, FSM states and helpers shared by iter_alu          |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
package alu_pkg;

    localparam logic [4:0] OP_MOV  = 5'b00000;
    localparam logic [4:0] OP_NOT  = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_SUB  = 5'b00011;
    localparam logic [4:0] OP_OR   = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_XOR  = 5'b00110;
    localparam logic [4:0] OP_SLT  = 5'b00111;
    localparam logic [4:0] OP_MUL  = 5'b10011;
    localparam logic [4:0] OP_DIVU = 5'b10100;
    localparam logic [4:0] OP_REMU = 5'b10101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MD_MUL = 2'd0,
        MD_DIV = 2'd1,
        MD_REM = 2'd2
    } md_mode_e;

    function automatic logic is_iterative(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/iter_muldiv_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | iter_muldiv_core : one-bit-per-cycle shift-add multiply / restoring div  |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
module iter_muldiv_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  md_mode_e         mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    md_mode_e         mode_q, mode_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH:0]   rem_q, rem_d;

    logic [WIDTH-1:0] acc_step;
    logic [WIDTH-1:0] quot_step;
    logic [WIDTH:0]   rem_step;
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;
    logic             trial_neg;

    // Next-step values; the final step is also presented as the result so the
    // top can capture it on the same edge the counter retires.
    always_comb begin
        acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
        shifted   = {rem_q, quot_q[WIDTH-1]};
        trial     = shifted - {2'b00, divisor_q};
        trial_neg = trial[WIDTH+1];
        rem_step  = trial_neg ? shifted[WIDTH:0] : trial[WIDTH:0];
        quot_step = {quot_q[WIDTH-2:0], ~trial_neg};
    end

    always_comb begin
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        quot_d    = quot_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        if (start) begin
            busy_d    = 1'b1;
            cnt_d     = '0;
            mode_d    = mode;
            acc_d     = '0;
            mcand_d   = op_a;
            mplier_d  = op_b;
            quot_d    = op_a;
            divisor_d = op_b;
            rem_d     = '0;
        end else if (busy_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            quot_d   = quot_step;
            rem_d    = rem_step;
            if (cnt_q == LAST_STEP) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        done = busy_q && (cnt_q == LAST_STEP);
        case (mode_q)
            MD_MUL:  result = acc_step;
            MD_DIV:  result = quot_step;
            default: result = rem_step[WIDTH-1:0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            mode_q    <= MD_MUL;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            quot_q    <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
        end else begin
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            quot_q    <= quot_d;
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/iter_alu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | iter_alu : multi-cycle ALU with valid/ready handshakes on both sides     |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
module iter_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [4:0]       Operation,
    input  logic [WIDTH-1:0] DataA,
    input  logic [WIDTH-1:0] DataB,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] ALUResult,
    output logic             OpError
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             error_q, error_d;

    logic [WIDTH-1:0] quick_result;
    logic             quick_error;
    logic             core_start;
    md_mode_e         core_mode;
    logic             core_done;
    logic [WIDTH-1:0] core_result;

    always_comb begin
        quick_result = '0;
        quick_error  = 1'b0;
        case (Operation)
            OP_MOV:  quick_result = DataA;
            OP_NOT:  quick_result = ~DataA;
            OP_ADD:  quick_result = DataA + DataB;
            OP_SUB:  quick_result = DataA - DataB;
            OP_OR:   quick_result = DataA | DataB;
            OP_AND:  quick_result = DataA & DataB;
            OP_XOR:  quick_result = DataA ^ DataB;
            OP_SLT:  quick_result = {{(WIDTH-1){1'b0}}, $signed(DataA) < $signed(DataB)};
            default: quick_error  = 1'b1;
        endcase
    end

    always_comb begin
        core_mode = (Operation == OP_MUL)  ? MD_MUL :
                    (Operation == OP_DIVU) ? MD_DIV : MD_REM;
    end

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        error_d    = error_q;
        core_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (InValid) begin
                    if (!is_iterative(Operation)) begin
                        result_d = quick_result;
                        error_d  = quick_error;
                        state_d  = DONE;
                    end else if ((Operation != OP_MUL) && (DataB == '0)) begin
                        // Divide by zero bypasses the core entirely.
                        result_d = (Operation == OP_DIVU) ? '1 : DataA;
                        error_d  = 1'b1;
                        state_d  = DONE;
                    end else begin
                        core_start = 1'b1;
                        error_d    = 1'b0;
                        state_d    = CALC;
                    end
                end
            end
            CALC: begin
                if (core_done) begin
                    result_d = core_result;
                    error_d  = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (OutReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            result_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            error_q  <= error_d;
        end
    end

    iter_muldiv_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk    (Clock),
        .rst    (Reset),
        .start  (core_start),
        .mode   (core_mode),
        .op_a   (DataA),
        .op_b   (DataB),
        .done   (core_done),
        .result (core_result)
    );

    assign InReady   = (state_q == IDLE);
    assign OutValid  = (state_q == DONE);
    assign ALUResult = result_q;
    assign OpError   = error_q;

endmodule
`default_nettype wire

// File: tb/tb_iter_alu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_iter_alu : scoreboard bench for iter_alu (WIDTH=32 and WIDTH=8)       |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
module tb_iter_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [4:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         err;

    logic         in_valid8 = 1'b0;
    logic         in_ready8;
    logic [4:0]   op8 = '0;
    logic [7:0]   a8 = '0;
    logic [7:0]   b8 = '0;
    logic         out_valid8;
    logic         out_ready8 = 1'b1;
    logic [7:0]   result8;
    logic         err8;

    iter_alu #(.WIDTH(W)) u_dut (
        .Clock(clk), .Reset(rst), .InValid(in_valid), .InReady(in_ready),
        .Operation(op), .DataA(a), .DataB(b), .OutValid(out_valid),
        .OutReady(out_ready), .ALUResult(result), .OpError(err)
    );

    iter_alu #(.WIDTH(8)) u_dut8 (
        .Clock(clk), .Reset(rst), .InValid(in_valid8), .InReady(in_ready8),
        .Operation(op8), .DataA(a8), .DataB(b8), .OutValid(out_valid8),
        .OutReady(out_ready8), .ALUResult(result8), .OpError(err8)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        logic        err;
        int unsigned acc_cyc;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   bp_mode  = 0;

    // Reference: spec rules computed with wide integer arithmetic.
    function automatic void ref_model(input int w, input logic [4:0] opc,
                                      input logic [63:0] a_in, input logic [63:0] b_in,
                                      output logic [63:0] res, output logic er,
                                      output int lat);
        logic [63:0] mask, x, y;
        longint      sx, sy;
        mask = (64'd1 << w) - 64'd1;
        x    = a_in & mask;
        y    = b_in & mask;
        sx   = x[w-1] ? longint'(x) - (longint'(1) << w) : longint'(x);
        sy   = y[w-1] ? longint'(y) - (longint'(1) << w) : longint'(y);
        er   = 1'b0;
        lat  = 1;
        res  = '0;
        case (opc)
            5'd0:  res = x;
            5'd1:  res = ~x;
            5'd2:  res = x + y;
            5'd3:  res = x - y;
            5'd4:  res = x | y;
            5'd5:  res = x & y;
            5'd6:  res = x ^ y;
            5'd7:  res = (sx < sy) ? 64'd1 : 64'd0;
            5'd19: begin res = x * y; lat = w + 1; end
            5'd20: if (y == 0) begin res = '1; er = 1'b1; end
                   else begin res = x / y; lat = w + 1; end
            5'd21: if (y == 0) begin res = x; er = 1'b1; end
                   else begin res = x % y; lat = w + 1; end
            default: begin res = '0; er = 1'b1; end
        endcase
        res = res & mask;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: compares the first cycle of each result, then its stability.
    logic         seen = 1'b0;
    logic [W-1:0] held_res;
    logic         held_err;
    exp_t         head;
    always @(negedge clk) begin
        if (rst) begin
            seen = 1'b0;
        end else if (out_valid) begin
            if (!seen) begin
                seen     = 1'b1;
                held_res = result;
                held_err = err;
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got 0x%0h, expected none", result);
                end else begin
                    head = sb_q[0];
                    check("result", 64'(result), head.res);
                    check("op_error", 64'(err), 64'(head.err));
                    check("latency", 64'(cyc - head.acc_cyc + 1), 64'(head.lat));
                end
            end else begin
                check("hold_result", 64'(result), 64'(held_res));
                check("hold_error", 64'(err), 64'(held_err));
            end
            if (out_ready) begin
                if (sb_q.size() != 0) void'(sb_q.pop_front());
                seen = 1'b0;
            end
        end
    end

    task automatic issue(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int          waited = 0;
        exp_t        e;
        logic [63:0] r;
        logic        er;
        int          l;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        op = o;
        a  = x;
        b  = y;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout: in_ready=%0b after %0d cycles, expected 1", in_ready, waited);
        end else begin
            ref_model(W, o, 64'(x), 64'(y), r, er, l);
            e.res = r; e.err = er; e.lat = l; e.acc_cyc = cyc + 1;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 5'($urandom);
        a  = $urandom;
        b  = $urandom;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(sb_q.size()), 64'd0);
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 6))
            0:       return '0;
            1:       return '1;
            2:       return W'(1);
            3:       return W'($urandom_range(0, 15));
            4:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic run8(input logic [4:0] o, input logic [7:0] x, input logic [7:0] y);
        logic [63:0] r;
        logic        er;
        int          l;
        int          lat;
        ref_model(8, o, 64'(x), 64'(y), r, er, l);
        @(posedge clk);
        #1;
        check("w8_in_ready", 64'(in_ready8), 64'd1);
        in_valid8 = 1'b1;
        op8 = o;
        a8  = x;
        b8  = y;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        a8  = 8'($urandom);
        b8  = 8'($urandom);
        lat = 1;
        while (!out_valid8 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("w8_result", 64'(result8), r);
        check("w8_op_error", 64'(err8), 64'(er));
        check("w8_latency", 64'(lat), 64'(l));
        @(posedge clk);
    endtask

    logic [4:0] legal_ops [12] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
                                   5'd19, 5'd20, 5'd21, 5'd31};

    initial begin
        int n;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_result", 64'(result), 64'd0);
        check("rst_op_error", 64'(err), 64'd0);
        check("rst_in_ready_released", 64'(in_ready), 64'd1);

        bp_mode = 0;
        issue(5'b00010, 32'hFFFF_FFFF, 32'h1);
        issue(5'b00111, 32'h8000_0000, 32'h1);
        issue(5'b10011, 32'h0001_0000, 32'h0001_0000);
        issue(5'b10011, 32'd1234, 32'd5678);
        issue(5'b10100, 32'd100, 32'd7);
        issue(5'b10101, 32'd100, 32'd7);
        issue(5'b10100, 32'd5, 32'd0);
        issue(5'b10101, 32'd5, 32'd0);
        issue(5'b11111, 32'h1234_5678, 32'h9ABC_DEF0);
        issue(5'b00011, 32'd0, 32'd1);
        drain("drain_directed");

        // Backpressure: result held, new requests ignored.
        bp_mode = 2;
        issue(5'b10011, $urandom, $urandom);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid_seen", 64'(out_valid), 64'd1);
        repeat (10) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            op = 5'b00010;
            a  = $urandom;
            b  = $urandom;
            @(negedge clk);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        bp_mode  = 0;
        n = 0;
        @(negedge clk);
        while (!(out_valid && out_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        check("bp_release_out_valid", 64'(out_valid), 64'd0);
        check("bp_no_extra", 64'(sb_q.size()), 64'd0);

        // Reset during a divide at step 10.
        issue(5'b10100, 32'hDEAD_BEEF, 32'd13);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_result", 64'(result), 64'd0);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        issue(5'b00010, 32'd2, 32'd3);
        drain("drain_after_reset");
        repeat (W + 5) @(negedge clk);
        check("midrst_no_late_output", 64'(out_valid), 64'd0);

        // Randomized traffic with random backpressure.
        bp_mode = 1;
        repeat (80) begin
            logic [4:0] o;
            if ($urandom_range(0, 9) == 0) o = 5'($urandom);
            else o = legal_ops[$urandom_range(0, 11)];
            issue(o, rand_operand(), rand_operand());
        end
        drain("drain_random");
        bp_mode = 0;

        // Narrow instance.
        run8(5'b10011, 8'd15, 8'd17);
        run8(5'b10100, 8'd200, 8'd3);
        run8(5'b10101, 8'd200, 8'd3);
        run8(5'b10100, 8'd9, 8'd0);
        run8(5'b00111, 8'h80, 8'h01);
        run8(5'b00010, 8'hFF, 8'h01);
        run8(5'b11111, 8'h12, 8'h34);
        repeat (15) run8(legal_ops[$urandom_range(0, 11)], 8'($urandom), 8'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
